// File: rtl/riscv_pkg.sv
// Shared register-file write-port types and constants.
package riscv_pkg;
  localparam int unsigned XLEN       = 32;
  localparam int unsigned NREG       = 32;
  localparam int unsigned REG_ADDR_W = 5;

  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_beat_t;

  typedef enum logic {
    PRIO_A = 1'b0,
    PRIO_B = 1'b1
  } prio_e;
endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; the pointer moves to the loser after each grant.
module rr_arb2
  import riscv_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  prio_e prio_q, prio_d;

  always_comb begin
    gnt = '0;
    if (req == 2'b11) begin
      gnt = (prio_q == PRIO_A) ? 2'b01 : 2'b10;
    end else begin
      gnt = req;
    end
  end

  always_comb begin
    prio_d = prio_q;
    if (advance) begin
      if (gnt[0]) begin
        prio_d = PRIO_B;
      end else if (gnt[1]) begin
        prio_d = PRIO_A;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prio_q <= PRIO_A;
    end else begin
      prio_q <= prio_d;
    end
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Arbitrates WB and load-return beats onto the register-file write port and
// tracks outstanding destination writes for hazard detection.
module wb_port_arbiter
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN = riscv_pkg::XLEN,
  parameter int unsigned NREG = riscv_pkg::NREG
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  a_valid,
  output logic                  a_ready,
  input  logic [REG_ADDR_W-1:0] a_rd,
  input  logic [XLEN-1:0]       a_data,
  input  logic                  b_valid,
  output logic                  b_ready,
  input  logic [REG_ADDR_W-1:0] b_rd,
  input  logic [XLEN-1:0]       b_data,
  input  logic                  set_valid,
  input  logic [REG_ADDR_W-1:0] set_rd,
  input  logic                  flush,
  output logic                  rf_we,
  output logic [REG_ADDR_W-1:0] rf_waddr,
  output logic [XLEN-1:0]       rf_wdata,
  output logic [NREG-1:0]       pending
);

  localparam logic [NREG-1:0] ONE = {{(NREG-1){1'b0}}, 1'b1};

  logic [1:0]            gnt;
  logic                  acc;
  logic [REG_ADDR_W-1:0] acc_rd;
  logic [XLEN-1:0]       acc_data;
  logic [NREG-1:0]       set_mask, clr_mask, pending_d;

  rr_arb2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     ({b_valid, a_valid}),
    .advance (acc),
    .gnt     (gnt)
  );

  // Readies are masked by rst so nothing is accepted while the pointer resets.
  assign a_ready = gnt[0] & ~rst;
  assign b_ready = gnt[1] & ~rst;
  assign acc     = a_ready | b_ready;

  always_comb begin
    acc_rd   = a_rd;
    acc_data = a_data;
    if (b_ready) begin
      acc_rd   = b_rd;
      acc_data = b_data;
    end
  end

  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (set_valid && set_rd != REG_ZERO) begin
      set_mask = ONE << set_rd;
    end
    if (acc && acc_rd != REG_ZERO) begin
      clr_mask = ONE << acc_rd;
    end
    // set beats clear; clear and flush both drop a bit, so they fold together
    pending_d    = (flush ? '0 : (pending & ~clr_mask)) | set_mask;
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
      pending  <= '0;
    end else begin
      rf_we   <= acc && (acc_rd != REG_ZERO);
      pending <= pending_d;
      if (acc) begin
        rf_waddr <= acc_rd;
        rf_wdata <= acc_data;
      end
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed self-checking bench for wb_port_arbiter.
module tb_wb_port_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        a_valid, b_valid, set_valid, flush;
  logic        a_ready, b_ready, rf_we;
  logic [4:0]  a_rd, b_rd, set_rd, rf_waddr;
  logic [31:0] a_data, b_data, rf_wdata, pending;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  always #5 clk = ~clk;

  wb_port_arbiter #(.XLEN(32), .NREG(32)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(a_ready), .a_rd(a_rd), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_rd(b_rd), .b_data(b_data),
    .set_valid(set_valid), .set_rd(set_rd), .flush(flush),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .pending(pending)
  );

  // Inputs change 1 time unit after the rising edge; outputs are read there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    a_valid = 0; b_valid = 0; set_valid = 0; flush = 0;
    a_rd = 0; b_rd = 0; set_rd = 0; a_data = 0; b_data = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1; a_valid = 1; b_valid = 1;
    a_rd = 5'd1; b_rd = 5'd2; a_data = 32'h1; b_data = 32'h2;
    for (int i = 0; i < 2; i++) begin
      #1;
      n_checks++; if ({a_ready, b_ready} !== 2'b00) begin n_fail++; $display("FAIL reset_ready got %b exp 00", {a_ready, b_ready}); end
      tick();
      n_checks++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL reset_we got %b exp 0", rf_we); end
      n_checks++; if (pending !== 32'h0) begin n_fail++; $display("FAIL reset_pending got %h exp 0", pending); end
      n_checks++; if (rf_waddr !== 5'd0 || rf_wdata !== 32'h0) begin n_fail++; $display("FAIL reset_port got %h/%h exp 0/0", rf_waddr, rf_wdata); end
    end
    rst = 0;
    #1;
    n_checks++; if ({a_ready, b_ready} !== 2'b10) begin n_fail++; $display("FAIL first_grant got %b exp 10", {a_ready, b_ready}); end
    idle_inputs();
    tick();
    n_checks++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL post_reset_idle_we got %b exp 0", rf_we); end
  endtask

  task automatic test_contention();
    logic [4:0]  exp_addr;
    logic [31:0] exp_data;
    a_valid = 1; a_rd = 5'd5; a_data = 32'h11;
    b_valid = 1; b_rd = 5'd6; b_data = 32'h22;
    for (int i = 0; i < 4; i++) begin
      #1;
      if (i % 2 == 0) begin
        n_checks++; if ({a_ready, b_ready} !== 2'b10) begin n_fail++; $display("FAIL contention_grant%0d got %b exp 10", i, {a_ready, b_ready}); end
        exp_addr = 5'd5; exp_data = 32'h11;
      end else begin
        n_checks++; if ({a_ready, b_ready} !== 2'b01) begin n_fail++; $display("FAIL contention_grant%0d got %b exp 01", i, {a_ready, b_ready}); end
        exp_addr = 5'd6; exp_data = 32'h22;
      end
      tick();
      n_checks++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, exp_addr, exp_data}) begin
        n_fail++; $display("FAIL contention_port%0d got we=%b a=%0d d=%h exp we=1 a=%0d d=%h", i, rf_we, rf_waddr, rf_wdata, exp_addr, exp_data);
      end
    end
    idle_inputs();
    tick();
    n_checks++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b0, 5'd6, 32'h22}) begin
      n_fail++; $display("FAIL idle_hold got we=%b a=%0d d=%h exp we=0 a=6 d=22", rf_we, rf_waddr, rf_wdata);
    end
  endtask

  task automatic test_x0_drop();
    a_valid = 1; a_rd = 5'd0; a_data = 32'hDEAD;
    #1;
    n_checks++; if (a_ready !== 1'b1) begin n_fail++; $display("FAIL x0_ready got %b exp 1", a_ready); end
    tick();
    a_valid = 0;
    n_checks++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL x0_we got %b exp 0", rf_we); end
    n_checks++; if (pending[0] !== 1'b0) begin n_fail++; $display("FAIL x0_pending0 got %b exp 0", pending[0]); end
    n_checks++; if (rf_wdata !== 32'hDEAD) begin n_fail++; $display("FAIL x0_data got %h exp dead", rf_wdata); end
    a_valid = 1; a_rd = 5'd1; b_valid = 1; b_rd = 5'd2;
    #1;
    n_checks++; if ({a_ready, b_ready} !== 2'b01) begin n_fail++; $display("FAIL x0_prio got %b exp 01", {a_ready, b_ready}); end
    idle_inputs();
    tick();
  endtask

  task automatic test_scoreboard();
    set_valid = 1; set_rd = 5'd7;
    tick();
    set_valid = 0;
    n_checks++; if (pending !== 32'h80) begin n_fail++; $display("FAIL sb_set got %h exp 00000080", pending); end
    set_valid = 1; set_rd = 5'd0;
    tick();
    set_valid = 0;
    n_checks++; if (pending !== 32'h80) begin n_fail++; $display("FAIL sb_set_x0 got %h exp 00000080", pending); end
    b_valid = 1; b_rd = 5'd7; b_data = 32'h77;
    #1;
    n_checks++; if (b_ready !== 1'b1) begin n_fail++; $display("FAIL sb_b_ready got %b exp 1", b_ready); end
    tick();
    b_valid = 0;
    n_checks++; if (pending !== 32'h0) begin n_fail++; $display("FAIL sb_clear got %h exp 0", pending); end
    n_checks++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd7, 32'h77}) begin
      n_fail++; $display("FAIL sb_port got we=%b a=%0d d=%h exp we=1 a=7 d=77", rf_we, rf_waddr, rf_wdata);
    end
  endtask

  task automatic test_set_clear_flush();
    set_valid = 1; set_rd = 5'd9;
    tick();
    a_valid = 1; a_rd = 5'd9; a_data = 32'h99;
    tick();
    a_valid = 0;
    n_checks++; if (pending !== 32'h200) begin n_fail++; $display("FAIL set_beats_clear got %h exp 00000200", pending); end
    n_checks++; if ({rf_we, rf_waddr} !== {1'b1, 5'd9}) begin n_fail++; $display("FAIL set_clear_port got we=%b a=%0d exp we=1 a=9", rf_we, rf_waddr); end
    set_rd = 5'd4;
    tick();
    set_rd = 5'd3;
    tick();
    n_checks++; if (pending !== 32'h218) begin n_fail++; $display("FAIL pre_flush got %h exp 00000218", pending); end
    flush = 1;
    tick();
    flush = 0; set_valid = 0;
    n_checks++; if (pending !== 32'h8) begin n_fail++; $display("FAIL flush_set got %h exp 00000008", pending); end
    flush = 1;
    tick();
    flush = 0;
    n_checks++; if (pending !== 32'h0) begin n_fail++; $display("FAIL flush_only got %h exp 0", pending); end
  endtask

  task automatic test_midstream_reset();
    a_valid = 1; a_rd = 5'd10; a_data = 32'hAA;
    set_valid = 1; set_rd = 5'd12;
    tick();
    set_valid = 0;
    n_checks++; if ({rf_we, rf_waddr, pending[12]} !== {1'b1, 5'd10, 1'b1}) begin
      n_fail++; $display("FAIL mid_pre got we=%b a=%0d p12=%b exp we=1 a=10 p12=1", rf_we, rf_waddr, pending[12]);
    end
    rst = 1; a_rd = 5'd11; a_data = 32'hBB; b_valid = 1; b_rd = 5'd13;
    #1;
    n_checks++; if ({a_ready, b_ready} !== 2'b00) begin n_fail++; $display("FAIL mid_ready got %b exp 00", {a_ready, b_ready}); end
    tick();
    rst = 0;
    n_checks++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b0, 5'd0, 32'h0}) begin
      n_fail++; $display("FAIL mid_port got we=%b a=%0d d=%h exp we=0 a=0 d=0", rf_we, rf_waddr, rf_wdata);
    end
    n_checks++; if (pending !== 32'h0) begin n_fail++; $display("FAIL mid_pending got %h exp 0", pending); end
    #1;
    n_checks++; if ({a_ready, b_ready} !== 2'b10) begin n_fail++; $display("FAIL mid_prio got %b exp 10", {a_ready, b_ready}); end
    idle_inputs();
    tick();
  endtask

  initial begin
    test_reset();
    test_contention();
    test_x0_drop();
    test_scoreboard();
    test_set_clear_flush();
    test_midstream_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
